// File: rtl/spi_4094_master_pkg.sv
// spi_4094_master_pkg
//   Shared definitions for the 4094 chain SPI initiator and the SPI mux wiring:
//   FSM state encoding and the default chain/timing parameters.
//   Optional feature macro used by the top: SPI_4094_READBACK_EN.
package spi_4094_master_pkg;

    localparam int DEF_WIDTH      = 16;  // 8 x number of 4094s
    localparam int DEF_CLK_DIV    = 4;   // clk cycles per sclk half-period
    localparam int DEF_STROBE_CYC = 2;   // clk cycles strobe is held high

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOW    = 2'd1,
        S_HIGH   = 2'd2,
        S_STROBE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_4094_master_if.sv
// spi_4094_master_if
//   Request/response and 4094 pin bundle for spi_4094_master.
//   Signals:
//     wdata  [WIDTH] word to shift out      valid  request a transfer
//     ready          initiator idle          done   1-cycle pulse after strobe
//     rdata  [WIDTH] word read back from QS' sclk   GLB_4094_CLK
//     sdata          GLB_4094_DATA           strobe GLB_4094_STROBE_CTL
//     oe             GLB_4094_OE             miso   GLB_4094_MISO_CTL (chain QS')
//   Modports: master = the initiator (spi_4094_master), slave = its user/environment.
interface spi_4094_master_if
    import spi_4094_master_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             valid;
    logic             ready;
    logic             done;
    logic             sclk;
    logic             sdata;
    logic             strobe;
    logic             oe;
    logic             miso;

    modport master (
        input  wdata, valid, miso,
        output ready, done, rdata, sclk, sdata, strobe, oe
    );

    modport slave (
        output wdata, valid, miso,
        input  ready, done, rdata, sclk, sdata, strobe, oe
    );
endinterface

// File: rtl/spi_4094_master_clk_div_phase.sv
// clk_div_phase
//   Restartable phase divider: while en_i is high the counter advances and
//   tick_o pulses on the last of every CLK_DIV cycles; the counter wraps to 0 on
//   each tick (phase change) or on restart_i.
//   Ports:
//     clk, rst    system clock, asynchronous active-high reset
//     en_i        count enable (inside a sclk phase)
//     restart_i   force the counter back to 0 (start of a transfer)
//     tick_o      last cycle of the current phase
//     first_o     first cycle of the current phase
module clk_div_phase #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o,
    output logic first_o
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o  = en_i && (cnt_q == LAST);
    assign first_o = (cnt_q == '0);

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_4094_master.sv
// spi_4094_master
//   FPGA-side initiator for the 4094 shift-register chain: shifts a WIDTH-bit
//   word out MSB first on sclk/sdata, pulses strobe to latch it into the 4094
//   storage registers, then asserts oe (sticky until reset).
//   Ports:
//     clk, rst  system clock, asynchronous active-high reset
//     bus       spi_4094_master_if.master (wdata/valid/ready/done/rdata and the
//               sclk/sdata/strobe/oe/miso pins)
//   Parameters: WIDTH (chain bits), CLK_DIV (clk per sclk half-period, >=1),
//               STROBE_CYC (strobe high cycles, >=1).
//   Macro SPI_4094_READBACK_EN: when defined, miso (chain QS') is shifted into a
//   second register and presented on rdata at done; otherwise rdata is 0.
module spi_4094_master
    import spi_4094_master_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int STROBE_CYC = DEF_STROBE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    spi_4094_master_if.master bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam int               STB_W    = $clog2(STROBE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic             sdata_q, sdata_d;
    logic             sclk_q, strobe_q, oe_q, oe_d, done_q, done_d;
    logic             div_en, div_restart, div_tick, div_first;

    clk_div_phase #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .rst       (rst),
        .en_i      (div_en),
        .restart_i (div_restart),
        .tick_o    (div_tick),
        .first_o   (div_first)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        div_en      = 1'b0;
        div_restart = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    sr_d        = bus.wdata;
                    cnt_d       = CNT_LAST;
                    div_restart = 1'b1;
                    state_d     = S_LOW;
                end
            end
            S_LOW: begin
                div_en = 1'b1;
                if (div_tick) state_d = S_HIGH;
            end
            S_HIGH: begin
                div_en = 1'b1;
                if (div_tick) begin
                    sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        stb_d   = '0;
                        state_d = S_STROBE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_LOW;
                    end
                end
            end
            S_STROBE: begin
                stb_d = stb_q + 1'b1;
                if (stb_q == STB_LAST) begin
                    done_d  = 1'b1;
                    oe_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // sdata only moves on entry to LOW, giving a full phase of setup before the rise.
        sdata_d = sdata_q;
        if (state_d == S_LOW && state_q != S_LOW) sdata_d = sr_d[WIDTH-1];
    end

    // Pin outputs are registered from the next state so sclk/strobe cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            stb_q    <= '0;
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
            strobe_q <= 1'b0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            stb_q    <= stb_d;
            sdata_q  <= sdata_d;
            sclk_q   <= (state_d == S_HIGH);
            strobe_q <= (state_d == S_STROBE);
            oe_q     <= oe_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = done_q;
    assign bus.sclk   = sclk_q;
    assign bus.sdata  = sdata_q;
    assign bus.strobe = strobe_q;
    assign bus.oe     = oe_q;

`ifdef SPI_4094_READBACK_EN
    logic [WIDTH-1:0] rb_q, rdata_q;

    // QS' changes on the 4094's falling clock, so it is stable through HIGH;
    // sample it once per bit on the first HIGH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_HIGH && div_first) rb_q <= {rb_q[WIDTH-2:0], bus.miso};
            if (done_d) rdata_q <= rb_q;
        end
    end

    assign bus.rdata = rdata_q;
`else
    logic unused_readback;
    assign unused_readback = bus.miso ^ div_first;
    assign bus.rdata       = '0;
`endif

endmodule

// File: tb/tb_spi_4094_master.sv
// tb_spi_4094_master
//   Scoreboard bench for spi_4094_master (WIDTH=16, CLK_DIV=2, STROBE_CYC=2).
//   A behavioural 4094 chain (shift on sclk rise, QS' on sclk fall, storage on
//   strobe fall) sits on the pins; an acceptance model pushes the expected
//   latched word, readback word and done cycle; a negedge monitor compares.
//   Honours SPI_4094_READBACK_EN for the expected rdata.
module tb_spi_4094_master;

    localparam int W    = 16;
    localparam int CD   = 2;
    localparam int SC   = 2;
    localparam int XFER = W * 2 * CD + SC;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] rb;
        int           done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_4094_master_if #(.WIDTH(W)) bus ();

    spi_4094_master #(.WIDTH(W), .CLK_DIV(CD), .STROBE_CYC(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural 4094 chain ----------------
    logic [W-1:0] chain_q   = 16'h1234;
    logic [W-1:0] latched_q = '0;
    logic         qs_q      = 1'b0;

    always @(posedge bus.sclk)  chain_q   <= {chain_q[W-2:0], bus.sdata};
    always @(negedge bus.sclk)  qs_q      <= chain_q[W-1];
    always @(negedge bus.strobe) latched_q <= chain_q;
    assign bus.miso = qs_q;

    // ---------------- scoreboard state ----------------
    exp_t         exp_q[$];
    int           n_cmp     = 0;
    int           n_fail    = 0;
    int           cyc       = 0;
    int           next_ok   = 0;
    int           n_acc     = 0;
    logic [W-1:0] exp_chain = 16'h1234;
    logic [W-1:0] prev_chain = '0;
    logic [W-1:0] inflight  = '0;
    logic [W-1:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Acceptance model: a request is taken whenever valid is high and the
    // previous transfer's done cycle has been reached.
    always @(posedge clk) begin
        if (!rst) begin
            exp_t e;
            cyc++;
            if (bus.valid && cyc >= next_ok) begin
                e.word    = bus.wdata;
`ifdef SPI_4094_READBACK_EN
                e.rb      = exp_chain;
`else
                e.rb      = '0;
`endif
                e.done_at = cyc + XFER;
                exp_q.push_back(e);
                next_ok    = cyc + XFER + 1;
                prev_chain = exp_chain;
                inflight   = bus.wdata;
                exp_chain  = bus.wdata;
                n_acc++;
            end
        end
    end

    // Monitor
    logic prev_sclk  = 1'b0;
    logic prev_sdata = 1'b0;
    int   stab       = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            check("ready", bus.ready, (cyc + 1 >= next_ok));
            check("strobe_while_sclk", bus.strobe & bus.sclk, 0);
            if (bus.sclk && !prev_sclk) begin
                check("sdata_setup", stab >= CD, 1);
                check("sdata_at_rise", bus.sdata, prev_sdata);
            end
            if (bus.sdata !== prev_sdata) stab = 1;
            else stab++;
            prev_sdata = bus.sdata;
            prev_sclk  = bus.sclk;

            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", bus.done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_at);
                    check("latched_word", latched_q, e.word);
                    check("rdata", bus.rdata, e.rb);
                    check("oe_at_done", bus.oe, 1);
                    check("sclk_at_done", bus.sclk, 0);
                    last_word = e.word;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].done_at) begin
                check("done_missing", bus.done, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] w);
        int start;
        start = n_acc;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.wdata = w;
        for (int i = 0; i < 200 && n_acc == start; i++) @(negedge clk);
        bus.valid = 1'b0;
        bus.wdata = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sclk"},   bus.sclk,   0);
        check({tag, "_sdata"},  bus.sdata,  0);
        check({tag, "_strobe"}, bus.strobe, 0);
        check({tag, "_oe"},     bus.oe,     0);
        check({tag, "_done"},   bus.done,   0);
        check({tag, "_ready"},  bus.ready,  1);
        check({tag, "_rdata"},  bus.rdata,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int rises;
        logic p;
        logic [W-1:0] w;

        bus.valid = 1'b0;
        bus.wdata = '0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Readback against a preloaded chain, then the mirror image.
        send(16'hFFFF);
        wait_idle();
        send(16'h0000);
        wait_idle();

        // Basic write.
        send(16'hA55A);
        wait_idle();
        check("oe_sticky", bus.oe, 1);

        // Busy: requests during a transfer are dropped.
        send(16'hA55A);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            bus.valid = 1'b1;
            bus.wdata = 16'h0000;
            @(negedge clk);
            bus.valid = 1'b0;
        end
        wait_idle();

        // Back-to-back with valid held high.
        @(negedge clk);
        start     = n_acc;
        bus.valid = 1'b1;
        bus.wdata = 16'h0001;
        for (int i = 0; i < 200 && n_acc == start; i++) @(negedge clk);
        bus.wdata = 16'h8000;
        for (int i = 0; i < 200 && n_acc == start + 1; i++) @(negedge clk);
        bus.valid = 1'b0;
        wait_idle();

        // Reset while bit 7 is on the wire.
        w = W'($urandom);
        send(w);
        rises = 0;
        p     = bus.sclk;
        for (int i = 0; i < 200 && rises < 7; i++) begin
            @(negedge clk);
            if (bus.sclk && !p) rises++;
            p = bus.sclk;
        end
        check("rises_before_reset", rises, 7);
        #1 rst = 1'b1;
        exp_q.delete();
        next_ok   = 0;
        exp_chain = (prev_chain << 7) | (inflight >> (W - 7));
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check("midreset_no_strobe", bus.strobe, 0);
        check("midreset_latched_kept", latched_q, last_word);
        rst = 1'b0;
        send(W'($urandom));
        wait_idle();

        // Random traffic, sometimes queued straight behind the previous word.
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                bus.valid = 1'b1;
                bus.wdata = W'($urandom);
                @(negedge clk);
                bus.valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
